regfile_wb_arb: RTL and testbench

REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

---
 rtl/regfile_wb_arb.sv | 163 ++++++++++++++++
 tb/tb_regfile_wb_arb.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arb.sv
// Register-file writeback arbiter: in-order pipeline writes win, long-latency LSU results queue in a FIFO
// with a per-register busy scoreboard. Define WB_ARB_STARVE_GUARD_EN to add the forced-drain starve guard.
module regfile_wb_arb #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_wa,
    input  logic [31:0] pipe_wd,
    input  logic        lsu_valid,
    input  logic [4:0]  lsu_wa,
    input  logic [31:0] lsu_wd,
    output logic        lsu_ready,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic        busy1,
    output logic        busy2,
    output logic        pipe_hold
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    if (DEPTH < 2 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_MAX < 1) begin : g_bad_param
        $error("regfile_wb_arb: DEPTH must be a power of 2 in 2..8 and STARVE_MAX >= 1");
    end

`ifdef WB_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;
`else
    typedef enum logic [1:0] {IDLE, PEND} state_t;
`endif

    logic [4:0]    fifo_wa [DEPTH];
    logic [31:0]   fifo_wd [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [31:0]   busy;
    state_t        state;
    state_t        state_next;

    logic pipe_write;
    logic enq;
    logic deq;

    assign pipe_write = !stall && pipe_valid && (pipe_wa != 5'd0);
    assign lsu_ready  = rst_n && (count < CW'(DEPTH)) && !busy[lsu_wa];
    assign enq        = lsu_valid && lsu_ready && (lsu_wa != 5'd0);
    assign deq        = rst_n && !stall && !pipe_write && (count != '0);

    assign busy1 = busy[ra1];
    assign busy2 = busy[ra2];

    always_comb begin
        rf_we = 1'b0;
        rf_wa = 5'd0;
        rf_wd = 32'd0;
        if (rst_n && pipe_write) begin
            rf_we = 1'b1;
            rf_wa = pipe_wa;
            rf_wd = pipe_wd;
        end else if (deq) begin
            rf_we = 1'b1;
            rf_wa = fifo_wa[head];
            rf_wd = fifo_wd[head];
        end
    end

    always_comb begin
        count_next = count;
        case ({enq, deq})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // NOTE: payload storage has no reset; count and busy alone define which entries are live.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_wa[tail] <= lsu_wa;
            fifo_wd[tail] <= lsu_wd;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            busy  <= '0;
        end else begin
            count <= count_next;
            if (enq) begin
                tail       <= tail + PW'(1);
                busy[lsu_wa] <= 1'b1;
            end
            if (deq) begin
                head <= head + PW'(1);
                busy[fifo_wa[head]] <= 1'b0;
            end
        end
    end

`ifdef WB_ARB_STARVE_GUARD_EN
    logic [SW-1:0] starve;
    logic [SW-1:0] starve_next;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (enq) state_next = PEND;
            PEND: begin
                if (count_next == '0) state_next = IDLE;
`ifdef WB_ARB_STARVE_GUARD_EN
                else if (starve == SW'(STARVE_MAX)) state_next = FORCE;
`endif
            end
`ifdef WB_ARB_STARVE_GUARD_EN
            FORCE: if (count_next == '0) state_next = IDLE;
`endif
            default: state_next = IDLE;
        endcase
    end

`ifdef WB_ARB_STARVE_GUARD_EN
    // In PEND the FIFO is non-empty, so a pipeline write always denies the head.
    always_comb begin
        starve_next = '0;
        if (state == PEND && state_next == PEND) begin
            if (deq)             starve_next = '0;
            else if (pipe_write) starve_next = starve + SW'(1);
            else                 starve_next = starve;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) starve <= '0;
        else        starve <= starve_next;
    end

    assign pipe_hold = (state == FORCE);
`else
    assign pipe_hold = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Randomised and directed bench for regfile_wb_arb against a queue-based reference model.
// Honours WB_ARB_STARVE_GUARD_EN the same way the design does.
module tb_regfile_wb_arb;

    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, pipe_valid, lsu_valid;
    logic [4:0]  pipe_wa, lsu_wa, ra1, ra2;
    logic [31:0] pipe_wd, lsu_wd;
    logic        lsu_ready, rf_we, busy1, busy2, pipe_hold;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    regfile_wb_arb #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .pipe_valid(pipe_valid), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd),
        .lsu_valid(lsu_valid), .lsu_wa(lsu_wa), .lsu_wd(lsu_wd), .lsu_ready(lsu_ready),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .ra1(ra1), .ra2(ra2), .busy1(busy1), .busy2(busy2), .pipe_hold(pipe_hold)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  wa;
        logic [31:0] wd;
    } entry_t;

    entry_t q[$];
    bit     busy_m [32];
    bit     hold_m;
    int     denied;
    int     n_vec = 0;
    int     n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Entered at posedge+1 with inputs applied; compares, advances the model, returns at next posedge+1.
    task automatic step();
        bit pw, rdy, deq, pending;
        #1;
        pw  = !stall && pipe_valid && pipe_wa != 5'd0;
        rdy = q.size() < DEPTH && !busy_m[lsu_wa];
        check("lsu_ready", lsu_ready, rdy);
        check("rf_we", rf_we, pw || (!stall && q.size() > 0));
        if (pw) begin
            check("rf_wa_pipe", rf_wa, pipe_wa);
            check("rf_wd_pipe", rf_wd, pipe_wd);
        end else if (!stall && q.size() > 0) begin
            check("rf_wa_fifo", rf_wa, q[0].wa);
            check("rf_wd_fifo", rf_wd, q[0].wd);
        end
        check("busy1", busy1, busy_m[ra1]);
        check("busy2", busy2, busy_m[ra2]);
        check("pipe_hold", pipe_hold, hold_m);

        pending = q.size() > 0 && !hold_m;
        deq     = !stall && !pw && q.size() > 0;
        if (deq) begin
            busy_m[q[0].wa] = 1'b0;
            void'(q.pop_front());
        end
        if (lsu_valid && rdy && lsu_wa != 5'd0) begin
            q.push_back('{wa: lsu_wa, wd: lsu_wd});
            busy_m[lsu_wa] = 1'b1;
        end
`ifdef WB_ARB_STARVE_GUARD_EN
        if (hold_m) begin
            if (q.size() == 0) hold_m = 1'b0;
        end else if (pending) begin
            if (q.size() == 0)             denied = 0;
            else if (denied == STARVE_MAX) begin hold_m = 1'b1; denied = 0; end
            else if (deq)                  denied = 0;
            else if (pw)                   denied++;
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic pv, input logic [4:0] pwa,
                         input logic lv, input logic [4:0] lwa, input logic [31:0] lwd,
                         input logic [4:0] r1);
        stall      = st;
        pipe_valid = pv;
        pipe_wa    = pwa;
        pipe_wd    = $urandom;
        lsu_valid  = lv;
        lsu_wa     = lwa;
        lsu_wd     = lwd;
        ra1        = r1;
        ra2        = 5'($urandom_range(0, 31));
        step();
    endtask

    // Asserts reset with busy-looking inputs, checks the quiet outputs, releases after two edges.
    task automatic reset_pulse(input logic [4:0] probe);
        rst_n      = 1'b0;
        stall      = 1'b0;
        pipe_valid = 1'b1;
        pipe_wa    = 5'd3;
        pipe_wd    = 32'hA5A5_0003;
        lsu_valid  = 1'b1;
        lsu_wa     = 5'd2;
        lsu_wd     = 32'h0;
        ra1        = probe;
        ra2        = 5'd2;
        #1;
        check("rst_rf_we", rf_we, 1'b0);
        check("rst_lsu_ready", lsu_ready, 1'b0);
        check("rst_pipe_hold", pipe_hold, 1'b0);
        check("rst_busy1", busy1, 1'b0);
        check("rst_busy2", busy2, 1'b0);
        q.delete();
        foreach (busy_m[i]) busy_m[i] = 1'b0;
        hold_m = 1'b0;
        denied = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        pipe_valid = 1'b0;
        lsu_valid  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int pct;
        logic pv;
        logic [4:0] pwa;

        reset_pulse(5'd0);

        // Single LSU result: busy on the next cycle, written one cycle after accept.
        drive(0, 0, 0, 1, 5, 32'hDEAD_BEEF, 5);
        drive(0, 0, 0, 0, 0, 0, 5);
        drive(0, 0, 0, 0, 0, 0, 5);

        // Writes to register 0 are dropped on both channels.
        drive(0, 0, 0, 1, 0, 32'h1234, 0);
        drive(0, 1, 0, 0, 0, 0, 0);

        // Fill the FIFO under constant pipeline traffic, then drain in order.
        drive(0, 1, 10, 1, 3, 32'h3333, 3);
        drive(0, 1, 11, 1, 4, 32'h4444, 4);
        drive(0, 1, 12, 1, 6, 32'h6666, 4);
        drive(0, 0, 0, 1, 6, 32'h6666, 3);
        drive(0, 0, 0, 1, 6, 32'h6666, 4);
        drive(0, 0, 0, 0, 0, 0, 6);
        drive(0, 0, 0, 0, 0, 0, 6);

        // Stall freezes the queued entry.
        drive(0, 0, 0, 1, 9, 32'h9999, 9);
        repeat (3) drive(1, 0, 0, 0, 0, 0, 9);
        drive(0, 0, 0, 0, 0, 0, 9);
        drive(0, 0, 0, 0, 0, 0, 9);

        // Reset with two entries queued.
        drive(0, 1, 13, 1, 1, 32'h1111, 1);
        drive(0, 1, 14, 1, 2, 32'h2222, 2);
        reset_pulse(5'd1);
        drive(0, 0, 0, 0, 0, 0, 1);

        // Sustained pipeline traffic starving a queued entry, then release.
        drive(0, 0, 0, 1, 8, 32'h8888, 8);
        repeat (7) drive(0, 1, 7, 0, 0, 0, 8);
        repeat (4) drive(0, 0, 0, 0, 0, 0, 8);

        for (int i = 0; i < 800; i++) begin
            case (i / 200)
                0:       pct = 30;
                1:       pct = 95;
                2:       pct = 60;
                default: pct = 10;
            endcase
            if (i == 400) reset_pulse(5'($urandom_range(1, 7)));
            pv  = ($urandom_range(0, 99) < pct);
            pwa = 5'($urandom_range(0, 31));
            if (busy_m[pwa]) pwa = 5'd0;
            drive(($urandom_range(0, 9) == 0), pv, pwa,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
